// File: rtl/serial_comparator_controller.sv
// Serial magnitude comparator: one shared 2-bit comparator walks the operands
// two bits per cycle, MSB slice first, and stops at the first unequal slice.

// Combinational 2-bit unsigned comparator; all outputs low when disabled.
module comparator_2_bit (
    input  logic       Enable_In,
    input  logic [1:0] A_In,
    input  logic [1:0] B_In,
    output logic       Gt_Out,
    output logic       Eq_Out,
    output logic       Lt_Out
);

    // Plain magnitude compare gated by the enable.
    always_comb begin
        Gt_Out = Enable_In & (A_In > B_In);
        Eq_Out = Enable_In & (A_In == B_In);
        Lt_Out = Enable_In & (A_In < B_In);
    end

endmodule

module serial_comparator_controller #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                            Clock_In,
    input  logic                            Reset_In,
    input  logic                            Start_In,
    input  logic [DATA_WIDTH-1:0]           Data_A_In,
    input  logic [DATA_WIDTH-1:0]           Data_B_In,
    output logic                            Busy_Out,
    output logic                            Done_Out,
    output logic                            A_gt_B_Out,
    output logic                            A_eq_B_Out,
    output logic                            A_lt_B_Out,
    output logic [$clog2(DATA_WIDTH/2):0]   Slices_Used_Out
);

    localparam int unsigned NumSlices = DATA_WIDTH / 2;
    // Index needs at least one bit even when there is a single slice.
    localparam int unsigned IdxW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
    localparam int unsigned CntW      = $clog2(NumSlices) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    gt_q, gt_d;
    logic                    eq_q, eq_d;
    logic                    lt_q, lt_d;
    logic [CntW-1:0]         used_q, used_d;

    logic [1:0]              a_slice;
    logic [1:0]              b_slice;
    logic                    slice_gt;
    logic                    slice_eq;
    logic                    slice_lt;
    logic [CntW-1:0]         used_now;

    // Select the current 2-bit slice {2k+1:2k} of each captured operand.
    always_comb begin
        a_slice  = 2'(a_q >> {idx_q, 1'b0});
        b_slice  = 2'(b_q >> {idx_q, 1'b0});
        // Slices examined so far, counting the one being evaluated now.
        used_now = CntW'(NumSlices) - CntW'(idx_q);
    end

    comparator_2_bit u_cmp (
        .Enable_In (1'b1),
        .A_In      (a_slice),
        .B_In      (b_slice),
        .Gt_Out    (slice_gt),
        .Eq_Out    (slice_eq),
        .Lt_Out    (slice_lt)
    );

    // Next-state logic: accept in idle, scan slices, early-exit on a difference.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        used_d  = used_q;

        case (state_q)
            StIdle: begin
                if (Start_In) begin
                    a_d     = Data_A_In;
                    b_d     = Data_B_In;
                    idx_d   = IdxW'(NumSlices - 1);
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (!slice_eq) begin
                    gt_d    = slice_gt;
                    eq_d    = 1'b0;
                    lt_d    = slice_lt;
                    used_d  = used_now;
                    state_d = StDone;
                end else if (idx_q == '0) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    used_d  = used_now;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; reset wins over any pending operation.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            used_q  <= used_d;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        Busy_Out        = (state_q != StIdle);
        Done_Out        = (state_q == StDone);
        A_gt_B_Out      = gt_q;
        A_eq_B_Out      = eq_q;
        A_lt_B_Out      = lt_q;
        Slices_Used_Out = used_q;
    end

endmodule

// File: tb/tb_serial_comparator_controller.sv
// Bench for serial_comparator_controller: 8-bit instance checked every cycle
// against a timeline model, plus a 4-bit instance swept over all operand pairs.
module tb_serial_comparator_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy, done, gt, eq, lt;
    logic [2:0] used;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, gt4, eq4, lt4;
    logic [1:0] used4;

    int checks = 0;
    int errors = 0;

    serial_comparator_controller #(.DATA_WIDTH(8)) u_dut (
        .Clock_In        (clk),
        .Reset_In        (rst),
        .Start_In        (start),
        .Data_A_In       (a_in),
        .Data_B_In       (b_in),
        .Busy_Out        (busy),
        .Done_Out        (done),
        .A_gt_B_Out      (gt),
        .A_eq_B_Out      (eq),
        .A_lt_B_Out      (lt),
        .Slices_Used_Out (used)
    );

    serial_comparator_controller #(.DATA_WIDTH(4)) u_dut4 (
        .Clock_In        (clk),
        .Reset_In        (rst),
        .Start_In        (start4),
        .Data_A_In       (a4),
        .Data_B_In       (b4),
        .Busy_Out        (busy4),
        .Done_Out        (done4),
        .A_gt_B_Out      (gt4),
        .A_eq_B_Out      (eq4),
        .A_lt_B_Out      (lt4),
        .Slices_Used_Out (used4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Number of 2-bit slices scanned MSB-first until the first difference.
    function automatic int slices_needed(input logic [7:0] a, input logic [7:0] b);
        for (int k = 3; k >= 0; k--) begin
            if (a[2*k +: 2] != b[2*k +: 2]) return 4 - k;
        end
        return 4;
    endfunction

    // Timeline model: an accepted request keeps the block busy for n+1 cycles,
    // the last of which is the done cycle where the result becomes visible.
    int         m_rem;
    logic       m_valid = 1'b0;
    logic       m_gt, m_eq, m_lt;
    logic [2:0] m_used;
    logic       p_gt, p_eq, p_lt;
    logic [2:0] p_used;

    always @(posedge clk) begin
        if (rst) begin
            m_rem   <= 0;
            m_gt    <= 1'b0;
            m_eq    <= 1'b0;
            m_lt    <= 1'b0;
            m_used  <= 3'd0;
            m_valid <= 1'b1;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin
                m_gt   <= p_gt;
                m_eq   <= p_eq;
                m_lt   <= p_lt;
                m_used <= p_used;
            end
        end else if (start) begin
            p_gt   <= (a_in > b_in);
            p_eq   <= (a_in == b_in);
            p_lt   <= (a_in < b_in);
            p_used <= 3'(slices_needed(a_in, b_in));
            m_rem  <= slices_needed(a_in, b_in) + 1;
        end
    end

    // Per-cycle comparison of the 8-bit instance against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_cycle", {24'd0, busy, done, gt, eq, lt, used},
                  {24'd0, (m_rem > 0), (m_rem == 1), m_gt, m_eq, m_lt, m_used});
        end
    end

    task automatic drive_start(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int busy_cnt;
        int cyc;
        logic saw_done;

        rst = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, gt, eq, lt, used}, 8'h00);
        // Reset wins over a simultaneous start.
        start = 1'b1; a_in = 8'hFF; b_in = 8'h00;
        @(negedge clk);
        check("reset_priority_busy", {31'd0, busy}, 32'd0);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);

        // C3 vs 43: top slice differs, gt after 2 cycles.
        drive_start(8'hC3, 8'h43);
        check("c3_cycle1_busy_done", {busy, done}, 2'b10);
        @(negedge clk);
        check("c3_done_flags_used", {done, gt, eq, lt, used}, {4'b1100, 3'd1});
        @(negedge clk);
        check("c3_after_idle_hold", {busy, done, gt, used}, {3'b001, 3'd1});

        // 5A vs 5A: all four slices, eq after 5 cycles.
        drive_start(8'h5A, 8'h5A);
        repeat (3) @(negedge clk);
        check("5a_cycle4_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("5a_done_flags_used", {done, gt, eq, lt, used}, {4'b1010, 3'd4});

        // 12 vs 13: decided in the last slice, busy for 5 cycles.
        @(negedge clk);
        drive_start(8'h12, 8'h13);
        busy_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            if (busy) busy_cnt++;
            if (i == 5) check("12_done_flags_used", {done, gt, eq, lt, used}, {4'b1001, 3'd4});
            if (i < 6) @(negedge clk);
        end
        check("12_busy_cycles", busy_cnt, 5);

        // 80 vs 00, then a start during compare that must be dropped.
        drive_start(8'h80, 8'h00);
        start = 1'b1; a_in = 8'h00; b_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        check("80_done_gt", {done, gt, eq, lt, used}, {4'b1100, 3'd1});
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("80_hold_no_second", {busy, done, gt, eq, lt, used}, {5'b00100, 3'd1});
        end

        // Reset during the second compare cycle aborts silently.
        drive_start(8'h5A, 8'h5A);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_all_zero", {busy, done, gt, eq, lt, used}, 8'h00);
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        drive_start(8'h5A, 8'h5A);
        repeat (4) @(negedge clk);
        check("after_abort_eq", {done, gt, eq, lt, used}, {4'b1010, 3'd4});
        @(negedge clk);

        // Exhaustive 4-bit sweep with latency check.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                logic [3:0] va, vb;
                int exp_used;
                va = 4'(ia);
                vb = 4'(ib);
                exp_used = (va[3:2] != vb[3:2]) ? 1 : 2;
                @(negedge clk);
                start4 = 1'b1; a4 = va; b4 = vb;
                @(negedge clk);
                start4 = 1'b0;
                a4 = ~va; b4 = va;
                cyc = 1;
                while (!done4 && cyc < 6) begin
                    @(negedge clk);
                    cyc++;
                end
                check("sweep4", {24'd0, gt4, eq4, lt4, used4, 3'(cyc)},
                      {24'd0, (va > vb), (va == vb), (va < vb), 2'(exp_used), 3'(exp_used + 1)});
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
